// File: rtl/a2d_conv_sched.sv
// a2d_conv_sched: periodic round of four A2D conversions over a shared SPI master.
// Each slot sends a channel command, waits a recovery gap, then reads the 12-bit result.
module a2d_conv_sched #(
    parameter bit         FAST_SIM  = 1'b1,
    parameter logic [2:0] CH_BATT   = 3'd0,
    parameter logic [2:0] CH_CURR   = 3'd1,
    parameter logic [2:0] CH_BRAKE  = 3'd3,
    parameter logic [2:0] CH_TORQUE = 3'd4,
    parameter int         GAP_CYC   = 4,
    parameter int         TMO_CYC   = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_done,
    input  logic [15:0] spi_rd,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        round_done,
    output logic        busy,
    output logic        tmo
);

    localparam int IW = FAST_SIM ? 11 : 14;
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT1,
        S_GAP,
        S_READ,
        S_WAIT2,
        S_NEXT
    } state_t;

    state_t        r_state;
    logic [1:0]    r_slot;
    logic [IW-1:0] r_ivl;
    logic          r_pend;
    logic [CW-1:0] r_cnt;
    logic          r_wrt;
    logic [15:0]   r_cmd;
    logic [11:0]   r_batt;
    logic [11:0]   r_curr;
    logic [11:0]   r_brake;
    logic [11:0]   r_torque;
    logic          r_rdone;
    logic          r_busy;
    logic          r_tmo;

    logic          w_wrap;
    logic          w_last;
    logic [1:0]    w_slot_nxt;
    logic [15:0]   w_cmd_nxt;
    logic          w_unused_rd;

    function automatic logic [2:0] ch_of(input logic [1:0] s);
        case (s)
            2'd0:    return CH_BATT;
            2'd1:    return CH_CURR;
            2'd2:    return CH_BRAKE;
            default: return CH_TORQUE;
        endcase
    endfunction

    assign w_wrap      = &r_ivl;
    assign w_last      = (r_slot == 2'd3);
    assign w_slot_nxt  = r_slot + 2'd1;
    assign w_cmd_nxt   = {2'b00, ch_of(w_slot_nxt), 11'h000};
    assign w_unused_rd = ^spi_rd[15:12];

    // Outputs are registered: pulses are set on the edge entering the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_slot   <= 2'd0;
            r_ivl    <= '0;
            r_pend   <= 1'b0;
            r_cnt    <= '0;
            r_wrt    <= 1'b0;
            r_cmd    <= 16'h0000;
            r_batt   <= 12'h000;
            r_curr   <= 12'h000;
            r_brake  <= 12'hFFF;
            r_torque <= 12'h000;
            r_rdone  <= 1'b0;
            r_busy   <= 1'b0;
            r_tmo    <= 1'b0;
        end else begin
            r_ivl   <= r_ivl + IW'(1);
            r_wrt   <= 1'b0;
            r_rdone <= 1'b0;
            r_tmo   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (r_pend) begin
                        r_pend  <= 1'b0;
                        r_slot  <= 2'd0;
                        r_busy  <= 1'b1;
                        r_wrt   <= 1'b1;
                        r_cmd   <= {2'b00, CH_BATT, 11'h000};
                        r_state <= S_CMD;
                    end
                end
                S_CMD: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT1;
                end
                S_WAIT1: begin
                    if (spi_done) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end else if (r_cnt == TMO_LAST) begin
                        r_tmo   <= 1'b1;
                        r_rdone <= w_last;
                        r_state <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_wrt   <= 1'b1;
                        r_cmd   <= 16'h0000;
                        r_state <= S_READ;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_READ: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (spi_done) begin
                        case (r_slot)
                            2'd0:    r_batt   <= spi_rd[11:0];
                            2'd1:    r_curr   <= spi_rd[11:0];
                            2'd2:    r_brake  <= spi_rd[11:0];
                            default: r_torque <= spi_rd[11:0];
                        endcase
                        r_rdone <= w_last;
                        r_state <= S_NEXT;
                    end else if (r_cnt == TMO_LAST) begin
                        r_tmo   <= 1'b1;
                        r_rdone <= w_last;
                        r_state <= S_NEXT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_slot  <= w_slot_nxt;
                        r_wrt   <= 1'b1;
                        r_cmd   <= w_cmd_nxt;
                        r_state <= S_CMD;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A wrap always leaves one round queued, even when IDLE consumes one now.
            if (w_wrap) r_pend <= 1'b1;
        end
    end

    assign spi_wrt    = r_wrt;
    assign spi_cmd    = r_cmd;
    assign batt       = r_batt;
    assign curr       = r_curr;
    assign brake      = r_brake;
    assign torque     = r_torque;
    assign round_done = r_rdone;
    assign busy       = r_busy;
    assign tmo        = r_tmo;

endmodule

// File: tb/tb_a2d_conv_sched.sv
// tb_a2d_conv_sched: randomized SPI responder plus a round-level result model.
// Scenarios: reset, normal rounds, gap spacing, timeout, overrun collapse, mid-round reset.
module tb_a2d_conv_sched;

    localparam int GAP = 4;
    localparam int TMO = 1023;
    localparam int IVL = 2048;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_done;
    logic [15:0] spi_rd;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic [11:0] batt;
    logic [11:0] curr;
    logic [11:0] brake;
    logic [11:0] torque;
    logic        round_done;
    logic        busy;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    int          txn_n = 0;
    int          drop_txn = -1;
    int          dly_min = 32;
    int          dly_max = 32;
    logic [15:0] rd_q[$];
    logic [15:0] cmd_log[$];
    int          wrt_t[$];
    int          done_t[$];
    logic        busy_log[$];

    int   rdone_cnt = 0;
    int   tmo_cnt = 0;
    int   tmo_t = 0;
    int   dbl_wrt = 0;
    logic prev_wrt = 1'b0;

    int          chs[4] = '{0, 1, 3, 4};
    logic [11:0] exp_v[4];

    always #5 clk = ~clk;

    a2d_conv_sched dut (
        .clk       (clk),
        .rst       (rst),
        .spi_done  (spi_done),
        .spi_rd    (spi_rd),
        .spi_wrt   (spi_wrt),
        .spi_cmd   (spi_cmd),
        .batt      (batt),
        .curr      (curr),
        .brake     (brake),
        .torque    (torque),
        .round_done(round_done),
        .busy      (busy),
        .tmo       (tmo)
    );

    function automatic int cyc();
        return int'($time / 10);
    endfunction

    // SPI master model: answers each wrt with a one-clock done after a random delay.
    initial begin
        spi_done = 1'b0;
        spi_rd   = 16'h0000;
        forever begin
            @(negedge clk);
            if (spi_wrt === 1'b1) begin
                int          d;
                int          k;
                logic [15:0] v;
                k = txn_n;
                txn_n++;
                cmd_log.push_back(spi_cmd);
                wrt_t.push_back(cyc());
                busy_log.push_back(busy);
                d = int'($urandom_range(dly_max, dly_min));
                if (k[0] && (k / 2) < rd_q.size()) v = rd_q[k/2];
                else v = 16'($urandom);
                if (k != drop_txn) begin
                    repeat (d - 1) @(negedge clk);
                    spi_done = 1'b1;
                    spi_rd   = v;
                    done_t.push_back(cyc());
                    @(negedge clk);
                    spi_done = 1'b0;
                    spi_rd   = 16'($urandom);
                end else begin
                    done_t.push_back(-1);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (tmo === 1'b1) begin
                tmo_cnt++;
                tmo_t = cyc();
            end
            if (round_done === 1'b1) rdone_cnt++;
            if (spi_wrt === 1'b1 && prev_wrt === 1'b1) dbl_wrt++;
            prev_wrt = spi_wrt;
        end
    end

    task automatic clear_logs();
        txn_n = 0;
        rd_q.delete();
        cmd_log.delete();
        wrt_t.delete();
        done_t.delete();
        busy_log.delete();
    endtask

    task automatic wait_round(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (round_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit          quiet;
        logic [11:0] got[4];
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_v = '{12'h000, 12'h000, 12'hFFF, 12'h000};
        quiet = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (spi_wrt !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++;
            $display("FAIL reset_quiet: got wrt/busy activity, want none");
        end
        got = '{batt, curr, brake, torque};
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (got[s] !== exp_v[s]) begin
                errors++;
                $display("FAIL reset_val[%0d]: got %h want %h", s, got[s], exp_v[s]);
            end
        end
        checks++;
        if ({round_done, tmo, spi_cmd} !== 18'h0) begin
            errors++;
            $display("FAIL reset_misc: got rd=%b tmo=%b cmd=%h want 0", round_done, tmo, spi_cmd);
        end
    endtask

    task automatic test_round(input bit rnd);
        bit          ok;
        int          rc0;
        int          nz;
        int          n;
        logic [15:0] ecmd;
        logic [11:0] got[4];
        clear_logs();
        if (rnd) begin
            for (int s = 0; s < 4; s++) rd_q.push_back(16'($urandom));
            dly_min = 2;
            dly_max = 80;
        end else begin
            rd_q.push_back(16'hF123);
            rd_q.push_back(16'h0456);
            rd_q.push_back(16'h0ABC);
            rd_q.push_back(16'h0FFF);
            dly_min = 32;
            dly_max = 32;
        end
        rc0 = rdone_cnt;
        wait_round(2 * IVL + 1000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL round_timeout: got no round_done, want one");
        end
        repeat (50) @(negedge clk);
        for (int s = 0; s < 4; s++) exp_v[s] = rd_q[s][11:0];
        checks++;
        if (rdone_cnt - rc0 != 1) begin
            errors++;
            $display("FAIL round_done_cnt: got %0d want 1", rdone_cnt - rc0);
        end
        checks++;
        if (cmd_log.size() != 8) begin
            errors++;
            $display("FAIL cmd_count: got %0d want 8", cmd_log.size());
        end
        n = (cmd_log.size() < 8) ? cmd_log.size() : 8;
        for (int i = 0; i < n; i++) begin
            ecmd = i[0] ? 16'h0000 : {2'b00, 3'(chs[i/2]), 11'h000};
            checks++;
            if (cmd_log[i] !== ecmd) begin
                errors++;
                $display("FAIL cmd_seq[%0d]: got %h want %h", i, cmd_log[i], ecmd);
            end
        end
        nz = 0;
        foreach (busy_log[i]) if (busy_log[i] !== 1'b1) nz++;
        checks++;
        if (nz != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL busy: got %0d low-at-wrt, busy_now=%b want 0,0", nz, busy);
        end
        got = '{batt, curr, brake, torque};
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (got[s] !== exp_v[s]) begin
                errors++;
                $display("FAIL result[%0d]: got %h want %h", s, got[s], exp_v[s]);
            end
        end
    endtask

    task automatic test_gap();
        int d;
        for (int k = 0; k < 4; k++) begin
            if (wrt_t.size() > 2 * k + 1 && done_t.size() > 2 * k) begin
                d = wrt_t[2*k+1] - done_t[2*k];
                checks++;
                if (d < GAP + 1) begin
                    errors++;
                    $display("FAIL gap[%0d]: got %0d clks want >= %0d", k, d, GAP + 1);
                end
            end
        end
        checks++;
        if (dbl_wrt != 0) begin
            errors++;
            $display("FAIL wrt_width: got %0d double-wide wrt, want 0", dbl_wrt);
        end
    endtask

    task automatic test_timeout();
        bit          ok;
        int          tc0;
        int          d;
        logic [11:0] got[4];
        clear_logs();
        for (int s = 0; s < 4; s++) rd_q.push_back(16'($urandom));
        dly_min  = 2;
        dly_max  = 40;
        drop_txn = 3;
        tc0      = tmo_cnt;
        wait_round(2 * IVL + 3000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_round: got no round_done, want one");
        end
        repeat (50) @(negedge clk);
        drop_txn = -1;
        for (int s = 0; s < 4; s++) if (s != 1) exp_v[s] = rd_q[s][11:0];
        checks++;
        if (tmo_cnt - tc0 != 1) begin
            errors++;
            $display("FAIL tmo_pulses: got %0d want 1", tmo_cnt - tc0);
        end
        d = (wrt_t.size() > 3) ? tmo_t - wrt_t[3] : -1;
        checks++;
        if (d < TMO || d > TMO + 3) begin
            errors++;
            $display("FAIL tmo_latency: got %0d want %0d..%0d", d, TMO, TMO + 3);
        end
        got = '{batt, curr, brake, torque};
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (got[s] !== exp_v[s]) begin
                errors++;
                $display("FAIL tmo_result[%0d]: got %h want %h", s, got[s], exp_v[s]);
            end
        end
    endtask

    task automatic test_overrun();
        bit          ok;
        int          rc0;
        int          t_rd;
        int          first;
        logic [11:0] got[4];
        clear_logs();
        for (int s = 0; s < 4; s++) rd_q.push_back(16'($urandom));
        dly_min = 520;
        dly_max = 560;
        wait_round(2 * IVL + 5000, ok);
        t_rd = cyc();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL long_round: got no round_done, want one");
        end
        for (int s = 0; s < 4; s++) exp_v[s] = rd_q[s][11:0];
        clear_logs();
        for (int s = 0; s < 4; s++) rd_q.push_back(16'($urandom));
        dly_min = 32;
        dly_max = 32;
        rc0 = rdone_cnt;
        repeat (1000) @(negedge clk);
        first = (wrt_t.size() > 0) ? wrt_t[0] - t_rd : 99999;
        checks++;
        if (first > 3) begin
            errors++;
            $display("FAIL followon_start: got %0d clks want <= 3", first);
        end
        checks++;
        if (rdone_cnt - rc0 != 1) begin
            errors++;
            $display("FAIL followon_count: got %0d rounds want 1", rdone_cnt - rc0);
        end
        for (int s = 0; s < 4; s++) exp_v[s] = rd_q[s][11:0];
        got = '{batt, curr, brake, torque};
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (got[s] !== exp_v[s]) begin
                errors++;
                $display("FAIL followon_result[%0d]: got %h want %h", s, got[s], exp_v[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit          seen;
        int          rc0;
        logic [11:0] got[4];
        clear_logs();
        for (int s = 0; s < 4; s++) rd_q.push_back(16'($urandom) | 16'h0001);
        dly_min = 32;
        dly_max = 32;
        seen = 1'b0;
        for (int i = 0; i < 2 * IVL + 1000; i++) begin
            @(negedge clk);
            if (wrt_t.size() >= 8) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach: got seen=%b busy=%b want 1,1", seen, busy);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_v = '{12'h000, 12'h000, 12'hFFF, 12'h000};
        got = '{batt, curr, brake, torque};
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (got[s] !== exp_v[s]) begin
                errors++;
                $display("FAIL mid_rst_val[%0d]: got %h want %h", s, got[s], exp_v[s]);
            end
        end
        checks++;
        if ({busy, spi_wrt, round_done, tmo} !== 4'b0) begin
            errors++;
            $display("FAIL mid_rst_ctl: got %b want 0000", {busy, spi_wrt, round_done, tmo});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rc0 = rdone_cnt;
        repeat (60) @(negedge clk);
        checks++;
        if (torque !== 12'h000 || busy !== 1'b0 || rdone_cnt != rc0) begin
            errors++;
            $display("FAIL mid_stray_done: got torque=%h busy=%b rd=%0d want 000,0,0", torque, busy, rdone_cnt - rc0);
        end
    endtask

    initial begin
        test_reset();
        test_round(1'b0);
        test_gap();
        for (int r = 0; r < 3; r++) begin
            test_round(1'b1);
            test_gap();
        end
        test_timeout();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
